// File: rtl/axi_outstanding_tracker.sv
// axi_outstanding_tracker: saturating AW/B and AR/R outstanding counters with stall limits and a drain handshake.
// Define AXI_OUTSTANDING_TRACKER_ERR_EN to build in the sticky over/underflow flag err_o.
module axi_outstanding_tracker #(
    parameter int COUNTER_SIZE = 4,
    parameter int MAX_AW       = 8,
    parameter int MAX_AR       = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    aw_sync_i,
    input  logic                    b_sync_i,
    input  logic                    ar_sync_i,
    input  logic                    r_sync_i,
    input  logic                    drain_req_i,
    input  logic                    err_clr_i,
    output logic                    busy_o,
    output logic [COUNTER_SIZE-1:0] aw_count_o,
    output logic [COUNTER_SIZE-1:0] ar_count_o,
    output logic                    aw_stall_o,
    output logic                    ar_stall_o,
    output logic                    drain_ack_o,
    output logic                    err_o
);
    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
    localparam logic [COUNTER_SIZE-1:0] CNT_MAX = '1;
    localparam logic [COUNTER_SIZE-1:0] AW_LIM  = COUNTER_SIZE'(MAX_AW);
    localparam logic [COUNTER_SIZE-1:0] AR_LIM  = COUNTER_SIZE'(MAX_AR);
    state_t                  state_q, state_d;
    logic [COUNTER_SIZE-1:0] aw_q, aw_d, ar_q, ar_d;
    logic                    aw_inc, aw_dec, ar_inc, ar_dec;
    always_comb begin
        aw_inc  = aw_sync_i & ~b_sync_i;
        aw_dec  = b_sync_i & ~aw_sync_i;
        ar_inc  = ar_sync_i & ~r_sync_i;
        ar_dec  = r_sync_i & ~ar_sync_i;
        aw_d    = (aw_inc && aw_q != CNT_MAX) ? aw_q + 1'b1 : (aw_dec && aw_q != '0) ? aw_q - 1'b1 : aw_q;
        ar_d    = (ar_inc && ar_q != CNT_MAX) ? ar_q + 1'b1 : (ar_dec && ar_q != '0) ? ar_q - 1'b1 : ar_q;
        // Dropping the request always returns to RUN; HALTED needs both registered counts at zero.
        state_d = !drain_req_i ? RUN :
                  (state_q == RUN) ? DRAIN :
                  (state_q == DRAIN && (aw_q != '0 || ar_q != '0)) ? DRAIN : HALTED;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            aw_q    <= '0;
            ar_q    <= '0;
            state_q <= RUN;
        end else begin
            aw_q    <= aw_d;
            ar_q    <= ar_d;
            state_q <= state_d;
        end
    end
    assign aw_count_o  = aw_q;
    assign ar_count_o  = ar_q;
    assign busy_o      = (aw_q != '0) || (ar_q != '0);
    assign aw_stall_o  = (aw_q >= AW_LIM) || (state_q != RUN);
    assign ar_stall_o  = (ar_q >= AR_LIM) || (state_q != RUN);
    assign drain_ack_o = (state_q == HALTED);
`ifdef AXI_OUTSTANDING_TRACKER_ERR_EN
    logic err_q, err_ev;
    // A same-cycle increment and decrement never counts as an error, even at the rails.
    assign err_ev = (aw_inc && aw_q == CNT_MAX) || (aw_dec && aw_q == '0) ||
                    (ar_inc && ar_q == CNT_MAX) || (ar_dec && ar_q == '0);
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) err_q <= 1'b0;
        else         err_q <= err_ev || (err_q && !err_clr_i);
    end
    assign err_o = err_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr_i;
    assign err_o          = 1'b0;
`endif
endmodule

// File: tb/tb_axi_outstanding_tracker.sv
// tb_axi_outstanding_tracker: directed + random stimulus, behavioural model feeds a scoreboard queue checked by a monitor.
module tb_axi_outstanding_tracker;
    localparam int CS     = 4;
    localparam int MAX_AW = 8;
    localparam int MAX_AR = 2;
    localparam int TOP    = (1 << CS) - 1;
    localparam int M_RUN = 0, M_DRAIN = 1, M_HALT = 2;

    logic clk_i = 0, rst_ni = 0;
    logic aw_sync_i = 0, b_sync_i = 0, ar_sync_i = 0, r_sync_i = 0, drain_req_i = 0, err_clr_i = 0;
    logic busy_o, aw_stall_o, ar_stall_o, drain_ack_o, err_o;
    logic [CS-1:0] aw_count_o, ar_count_o;

    axi_outstanding_tracker #(.COUNTER_SIZE(CS), .MAX_AW(MAX_AW), .MAX_AR(MAX_AR)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .aw_sync_i(aw_sync_i), .b_sync_i(b_sync_i),
        .ar_sync_i(ar_sync_i), .r_sync_i(r_sync_i), .drain_req_i(drain_req_i), .err_clr_i(err_clr_i),
        .busy_o(busy_o), .aw_count_o(aw_count_o), .ar_count_o(ar_count_o), .aw_stall_o(aw_stall_o),
        .ar_stall_o(ar_stall_o), .drain_ack_o(drain_ack_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { int busy; int awc; int arc; int aws; int ars; int ack; int err; } exp_t;
    exp_t sb[$];
    int n_chk = 0, n_fail = 0;
    int wc = 0, rc = 0, st = M_RUN, er = 0;

    function automatic void chk(input string name, input logic [31:0] act, input int req);
        n_chk++;
        if (act !== 32'(req)) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.busy = (wc != 0 || rc != 0);
        e.awc  = wc;
        e.arc  = rc;
        e.aws  = (wc >= MAX_AW || st != M_RUN);
        e.ars  = (rc >= MAX_AR || st != M_RUN);
        e.ack  = (st == M_HALT);
        e.err  = er;
        return e;
    endfunction

    // One clock of the specified behaviour: counts saturate, the FSM reads the counts from before this edge.
    task automatic model_edge(input bit aw, b, ar, r, dr, clr);
        int  dw, dr_c, nst;
        bit  ev;
        if (!rst_ni) begin
            wc = 0; rc = 0; st = M_RUN; er = 0;
            return;
        end
        dw   = int'(aw) - int'(b);
        dr_c = int'(ar) - int'(r);
        ev   = (wc + dw > TOP) || (wc + dw < 0) || (rc + dr_c > TOP) || (rc + dr_c < 0);
        if (!dr)                            nst = M_RUN;
        else if (st == M_RUN)               nst = M_DRAIN;
        else if (wc == 0 && rc == 0)        nst = M_HALT;
        else                                nst = st;
        wc = (wc + dw > TOP) ? TOP : (wc + dw < 0) ? 0 : wc + dw;
        rc = (rc + dr_c > TOP) ? TOP : (rc + dr_c < 0) ? 0 : rc + dr_c;
        st = nst;
`ifdef AXI_OUTSTANDING_TRACKER_ERR_EN
        er = ev ? 1 : clr ? 0 : er;
`else
        er = (ev && clr) ? 0 : 0;
`endif
    endtask

    task automatic step(input bit aw, b, ar, r, dr, clr);
        @(negedge clk_i);
        aw_sync_i = aw; b_sync_i = b; ar_sync_i = ar; r_sync_i = r; drain_req_i = dr; err_clr_i = clr;
        model_edge(aw, b, ar, r, dr, clr);
        sb.push_back(model_out());
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"},  busy_o, 0);
        chk({tag, "_awc"},   aw_count_o, 0);
        chk({tag, "_arc"},   ar_count_o, 0);
        chk({tag, "_aws"},   aw_stall_o, 0);
        chk({tag, "_ars"},   ar_stall_o, 0);
        chk({tag, "_ack"},   drain_ack_o, 0);
        chk({tag, "_err"},   err_o, 0);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_ni = 0;
        aw_sync_i = 0; b_sync_i = 0; ar_sync_i = 0; r_sync_i = 0; drain_req_i = 0; err_clr_i = 0;
        model_edge(0, 0, 0, 0, 0, 0);
        #1 check_zero("async_rst");
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        @(negedge clk_i);
        rst_ni = 1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk_i);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("busy_o",      busy_o,      e.busy);
                chk("aw_count_o",  aw_count_o,  e.awc);
                chk("ar_count_o",  ar_count_o,  e.arc);
                chk("aw_stall_o",  aw_stall_o,  e.aws);
                chk("ar_stall_o",  ar_stall_o,  e.ars);
                chk("drain_ack_o", drain_ack_o, e.ack);
                chk("err_o",       err_o,       e.err);
            end
        end
    end

    initial begin : stim
        bit dr;
        #1 check_zero("por");
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1;
        // write count up and back down
        repeat (3) step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        repeat (2) step(0, 1, 0, 0, 0, 0);
        // read stall at the MAX_AR limit
        repeat (2) step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        // drain with one write outstanding
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 1, 0);
        repeat (2) step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        // saturation at the top and error clear
        do_reset();
        repeat (16) step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 1);
        step(1, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        // simultaneous inc/dec at zero, then underflow
        do_reset();
        step(1, 1, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        // reset in the middle of a drain
        do_reset();
        repeat (3) step(1, 0, 0, 0, 0, 0);
        repeat (2) step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        do_reset();
        step(0, 0, 0, 0, 0, 0);
        // random traffic; completions favoured while draining so HALTED is reachable
        dr = 0;
        for (int i = 0; i < 3000; i++) begin
            int p_req;
            if ($urandom_range(0, 99) < 4) dr = ~dr;
            p_req = dr ? 10 : 45;
            step($urandom_range(0, 99) < p_req, $urandom_range(0, 99) < 45,
                 $urandom_range(0, 99) < p_req, $urandom_range(0, 99) < 45,
                 dr, $urandom_range(0, 99) < 5);
            if ($urandom_range(0, 999) < 3) do_reset();
        end
        step(0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk_i);
        #2;
        chk("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/axi_outstanding_tracker.md
AXI_OUTSTANDING_TRACKER -- requirements
Module: axi_outstanding_tracker

Interface
REQ-001 SHALL have parameter COUNTER_SIZE, default 4, width of each outstanding-transaction counter.
REQ-002 SHALL have parameter MAX_AW, default 8, write-outstanding limit at which aw_stall_o asserts; legal range 1..2^COUNTER_SIZE-1.
REQ-003 SHALL have parameter MAX_AR, default 8, read-outstanding limit at which ar_stall_o asserts; legal range 1..2^COUNTER_SIZE-1.
REQ-004 SHALL have port clk_i  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-006 SHALL have port aw_sync_i  input  1  one-cycle pulse per accepted AW handshake.
REQ-007 SHALL have port b_sync_i  input  1  one-cycle pulse per accepted B handshake.
REQ-008 SHALL have port ar_sync_i  input  1  one-cycle pulse per accepted AR handshake.
REQ-009 SHALL have port r_sync_i  input  1  one-cycle pulse per accepted R beat with RLAST.
REQ-010 SHALL have port drain_req_i  input  1  level request to quiesce traffic.
REQ-011 SHALL have port err_clr_i  input  1  pulse clearing sticky error.
REQ-012 SHALL have port busy_o  output  1  any transaction outstanding.
REQ-013 SHALL have port aw_count_o  output  COUNTER_SIZE  outstanding writes.
REQ-014 SHALL have port ar_count_o  output  COUNTER_SIZE  outstanding reads.
REQ-015 SHALL have port aw_stall_o  output  1  upstream must not issue new AW.
REQ-016 SHALL have port ar_stall_o  output  1  upstream must not issue new AR.
REQ-017 SHALL have port drain_ack_o  output  1  drain complete, no traffic outstanding.
REQ-018 SHALL have port err_o  output  1  sticky counter over/underflow flag.

Function
REQ-019 Write counter SHALL: aw_sync_i=1,b_sync_i=0 -> +1; aw_sync_i=0,b_sync_i=1 -> -1; both equal -> hold; update takes effect next rising edge.
REQ-020 Read counter SHALL follow REQ-019 using ar_sync_i/r_sync_i.
REQ-021 Increment at 2^COUNTER_SIZE-1 SHALL hold value (saturate, no wrap); this is an overflow event.
REQ-022 Decrement at 0 SHALL hold 0 (no wrap); this is an underflow event.
REQ-023 Simultaneous increment and decrement at 0 or at max SHALL hold value and SHALL NOT be an error event.
REQ-024 busy_o SHALL be combinational from registers: 1 iff aw_count_o!=0 or ar_count_o!=0.
REQ-025 aw_stall_o SHALL be 1 iff aw_count_o>=MAX_AW or drain state!=RUN; ar_stall_o likewise with ar_count_o/MAX_AR; both derived from registered state only.
REQ-026 Drain FSM states SHALL be RUN, DRAIN, HALTED.
REQ-027 RUN->DRAIN when drain_req_i=1 at a clock edge.
REQ-028 DRAIN->HALTED when drain_req_i=1 and both registered counts are 0 at a clock edge; DRAIN->RUN when drain_req_i=0.
REQ-029 HALTED->RUN when drain_req_i=0; stays HALTED otherwise.
REQ-030 drain_ack_o SHALL be 1 iff state==HALTED (registered, one cycle after counts reach 0 in DRAIN).
REQ-031 Completions (b_sync_i/r_sync_i) SHALL be counted in all FSM states; sync pulses arriving in DRAIN/HALTED despite stall SHALL still be counted.
REQ-032 Counters SHALL be independent of FSM state.

Reset
REQ-033 On rst_ni=0, asynchronously: both counters 0, FSM RUN, error flag 0; hence busy_o=0, aw_stall_o=0, ar_stall_o=0, drain_ack_o=0, err_o=0.
REQ-034 Reset mid-operation SHALL discard all outstanding counts and any drain in progress.

Configuration
REQ-035 Macro AXI_OUTSTANDING_TRACKER_ERR_EN SHALL control error detection.
REQ-036 With macro defined: any overflow/underflow event sets err_o next edge; err_o stays 1 until err_clr_i=1; simultaneous error event and err_clr_i leaves err_o=1.
REQ-037 Without macro: err_o constant 0, err_clr_i ignored, error logic absent; saturation per REQ-021/022 unchanged.

Verification
REQ-038 After reset, 3 aw_sync_i pulses then 1 b_sync_i -> aw_count_o=2, busy_o=1; 2 more b_sync_i -> aw_count_o=0, busy_o=0.
REQ-039 MAX_AR=2: 2 ar_sync_i pulses -> ar_stall_o=1 the cycle after second pulse; one r_sync_i -> ar_stall_o=0 next cycle.
REQ-040 aw_count_o=1, drain_req_i=1 -> both stalls 1 next cycle, drain_ack_o=0; b_sync_i -> drain_ack_o=1 two edges later; drain_req_i=0 -> drain_ack_o=0, stalls 0 next cycle.
REQ-041 COUNTER_SIZE=4, 16 aw_sync_i pulses -> aw_count_o=15, err_o=1 (macro on) / 0 (macro off); err_clr_i pulse -> err_o=0.
REQ-042 aw_count_o=0, aw_sync_i and b_sync_i together -> aw_count_o=0, err_o=0; b_sync_i alone at 0 -> aw_count_o=0, err_o=1 (macro on).
REQ-043 rst_ni=0 asserted mid-drain with counts 3/2 -> all outputs 0 immediately, FSM RUN after release.
